// File: rtl/sextet_unpacker_pkg.sv
// Shared constants for the ADC sextet FIFO word layout and the unpacker state encoding.
// The packer on the write side of the FIFO uses the same field positions.
package sextet_unpacker_pkg;

  localparam int WORD_W         = 64;
  localparam int ADC_BIT        = 63;
  localparam int SHIFT_BIT      = 62;
  localparam int SW_BIT         = 61;
  localparam int CNT_MSB        = 60;
  localparam int CNT_LSB        = 48;
  localparam int CNT_W          = 13;
  localparam int BYTES_PER_WORD = 6;
  localparam int POS_W          = 3;
  localparam int FRAME_CNT_W    = 24;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] word_count(input logic [WORD_W-1:0] w);
    return w[CNT_MSB:CNT_LSB];
  endfunction

  function automatic logic [2:0] word_flags(input logic [WORD_W-1:0] w);
    return {w[ADC_BIT], w[SHIFT_BIT], w[SW_BIT]};
  endfunction

endpackage

// File: rtl/sextet_unpacker_if.sv
// FIFO read port, byte stream and statistics bundle of the sextet unpacker.
// slave is the unpacker's view; master is the view of whoever drives the FIFO side and consumes bytes.
interface sextet_unpacker_if
  import sextet_unpacker_pkg::*;
#(
  parameter int IDX_W = 16,
  parameter int ERR_W = 16
) ();

  logic [WORD_W-1:0]      FifoData;
  logic                   FifoEmpty;
  logic                   FifoRead;
  logic [7:0]             SampleData;
  logic                   SampleValid;
  logic                   SampleReady;
  logic [IDX_W-1:0]       SampleIndex;
  logic                   FrameStart;
  logic [2:0]             HeaderFlags;
  logic [CNT_W-1:0]       LastFrameLength;
  logic [FRAME_CNT_W-1:0] FrameCount;
  logic                   SeqError;
  logic [ERR_W-1:0]       ErrorCount;
  logic                   ClearStats;

  modport slave (
    input  FifoData, FifoEmpty, SampleReady, ClearStats,
    output FifoRead, SampleData, SampleValid, SampleIndex, FrameStart,
           HeaderFlags, LastFrameLength, FrameCount, SeqError, ErrorCount
  );

  modport master (
    output FifoData, FifoEmpty, SampleReady, ClearStats,
    input  FifoRead, SampleData, SampleValid, SampleIndex, FrameStart,
           HeaderFlags, LastFrameLength, FrameCount, SeqError, ErrorCount
  );

endinterface

// File: rtl/sextet_skid_reg.sv
// One-entry prefetch buffer for the FIFO read port plus tracking of the single outstanding read.
// 'word' presents the skid entry if held, otherwise the word arriving on fifo_data this cycle.
module sextet_skid_reg
  import sextet_unpacker_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  input  logic [WORD_W-1:0] fifo_data,
  input  logic              take,
  output logic              fifo_read,
  output logic              avail,
  output logic [WORD_W-1:0] word
);

  logic              outstanding;
  logic              skid_full;
  logic [WORD_W-1:0] skid_word;

  // Gated by reset so no pop reaches the FIFO while the block is held in reset.
  assign fifo_read = rst_n && !fifo_empty && !outstanding && !skid_full;
  assign avail     = skid_full || outstanding;
  assign word      = skid_full ? skid_word : fifo_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outstanding <= 1'b0;
      skid_full   <= 1'b0;
      skid_word   <= '0;
    end else begin
      outstanding <= fifo_read;
      // A read is never issued while the skid is full, so an arrival always finds it empty.
      if (outstanding && !take) begin
        skid_full <= 1'b1;
        skid_word <= fifo_data;
      end else if (take) begin
        skid_full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sextet_unpacker.sv
// Read side of the ADC sextet FIFO: replays each packed word as six bytes with index and frame markers.
// Define SEQ_CHECK_EN to build the count-0 hunting, continuity check, SeqError and ErrorCount.
module sextet_unpacker
  import sextet_unpacker_pkg::*;
#(
  parameter int IDX_W = 16,
  parameter int ERR_W = 16
) (
  input logic               InputClock,
  input logic               ResetN,
  sextet_unpacker_if.slave  bus
);

`ifdef SEQ_CHECK_EN
  localparam state_t RESET_STATE = ST_HUNT;
`else
  localparam state_t RESET_STATE = ST_LOAD;
`endif

  state_t                 state, state_n;
  logic [WORD_W-1:0]      shift_word;
  logic [POS_W-1:0]       byte_pos;
  logic                   valid;
  logic [CNT_W-1:0]       prev_cnt;
  logic                   first_word;
  logic [CNT_W-1:0]       last_len;
  logic [FRAME_CNT_W-1:0] frame_cnt;

  logic              avail;
  logic              take;
  logic [WORD_W-1:0] in_word;
  logic [CNT_W-1:0]  in_cnt;
  logic [CNT_W-1:0]  cur_cnt;
  logic              accept;
  logic              last_byte;
  logic              boundary;
  logic              keep;
  logic              load;
  logic              violation;
  logic              frame_evt;

  sextet_skid_reg u_skid (
    .clk        (InputClock),
    .rst_n      (ResetN),
    .fifo_empty (bus.FifoEmpty),
    .fifo_data  (bus.FifoData),
    .take       (take),
    .fifo_read  (bus.FifoRead),
    .avail      (avail),
    .word       (in_word)
  );

  assign in_cnt    = word_count(in_word);
  assign cur_cnt   = word_count(shift_word);
  assign accept    = valid && bus.SampleReady;
  assign last_byte = (byte_pos == POS_W'(BYTES_PER_WORD - 1));
  assign boundary  = (in_cnt == '0);

`ifdef SEQ_CHECK_EN
  // A repeated count fails the prev+1 test, so duplicates land here as violations.
  assign keep = boundary || (in_cnt == prev_cnt + CNT_W'(1));
`else
  assign keep = 1'b1;
`endif

  always_comb begin
    state_n   = state;
    take      = 1'b0;
    load      = 1'b0;
    violation = 1'b0;
    case (state)
      ST_HUNT: begin
        if (avail) begin
          take = 1'b1;
          if (boundary) begin
            load    = 1'b1;
            state_n = ST_EMIT;
          end
        end
      end
      ST_LOAD: begin
        if (avail) begin
          take = 1'b1;
          if (keep) begin
            load    = 1'b1;
            state_n = ST_EMIT;
          end else begin
            violation = 1'b1;
            state_n   = ST_HUNT;
          end
        end
      end
      ST_EMIT: begin
        if (accept && last_byte) begin
          if (avail) begin
            take = 1'b1;
            if (keep) begin
              load = 1'b1;
            end else begin
              violation = 1'b1;
              state_n   = ST_HUNT;
            end
          end else begin
            state_n = ST_LOAD;
          end
        end
      end
      default: state_n = RESET_STATE;
    endcase
  end

  assign frame_evt = load && boundary && !first_word;

  // Shift register stage: one word held, bytes walked out by byte_pos.
  always_ff @(posedge InputClock) begin
    if (!ResetN) begin
      state      <= RESET_STATE;
      shift_word <= '0;
      byte_pos   <= '0;
      valid      <= 1'b0;
      prev_cnt   <= '0;
      first_word <= 1'b1;
    end else begin
      state <= state_n;
      if (load) begin
        shift_word <= in_word;
        byte_pos   <= '0;
        valid      <= 1'b1;
        prev_cnt   <= in_cnt;
        first_word <= 1'b0;
      end else if (accept) begin
        if (last_byte) begin
          byte_pos <= '0;
          valid    <= 1'b0;
        end else begin
          byte_pos <= byte_pos + POS_W'(1);
        end
      end
      if (violation) first_word <= 1'b1;
    end
  end

  always_ff @(posedge InputClock) begin
    if (!ResetN || bus.ClearStats) begin
      last_len  <= '0;
      frame_cnt <= '0;
    end else if (frame_evt) begin
      last_len  <= prev_cnt;
      frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
    end
  end

`ifdef SEQ_CHECK_EN
  logic             seq_err;
  logic [ERR_W-1:0] err_cnt;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  always_ff @(posedge InputClock) begin
    if (!ResetN) begin
      seq_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      seq_err <= violation;
      if (bus.ClearStats)  err_cnt <= '0;
      else if (violation)  err_cnt <= sat_inc(err_cnt);
    end
  end

  assign bus.SeqError   = seq_err;
  assign bus.ErrorCount = err_cnt;
`else
  assign bus.SeqError   = 1'b0;
  assign bus.ErrorCount = '0;
`endif

  assign bus.SampleData      = shift_word[{byte_pos, 3'b000} +: 8];
  assign bus.SampleValid     = valid;
  assign bus.SampleIndex     = IDX_W'(cur_cnt) * IDX_W'(BYTES_PER_WORD) + IDX_W'(byte_pos);
  assign bus.FrameStart      = valid && (cur_cnt == '0) && (byte_pos == '0);
  assign bus.HeaderFlags     = word_flags(shift_word);
  assign bus.LastFrameLength = last_len;
  assign bus.FrameCount      = frame_cnt;

endmodule

// File: doc/sextet_unpacker.md
Name: sextet_unpacker

Overview:
- Read side of the ADC sextet FIFO. Pops 64-bit packed words and checks the 13-bit sextet counter for continuity and frame boundaries.
- Replays the six payload bytes as a byte stream with sample index and frame markers. Exposes the header flags and frame statistics to the PC control path.
- Sits between the packet FIFO read port and the downstream accumulator/transfer logic.

Parameters:
- IDX_W, 16, width of SampleIndex (sextet*6+point; must hold 8192*6-1).
- ERR_W, 16, width of ErrorCount (saturating).

Ports:
- InputClock  in  1  single clock for all logic (FIFO read side).
- ResetN  in  1  synchronous reset, active-low.
- FifoData  in  64  FIFO word: [63]=ADC select, [62]=half-clock shift, [61]=switcher, [60:48]=sextet count, [47:0]=bytes 5..0.
- FifoEmpty  in  1  FIFO empty flag.
- FifoRead  out  1  pop strobe; data is valid on FifoData exactly one cycle later.
- SampleData  out  8  current byte.
- SampleValid  out  1  byte valid.
- SampleReady  in  1  downstream accept.
- SampleIndex  out  IDX_W  position of byte in frame.
- FrameStart  out  1  high with the first byte of a frame (index 0).
- HeaderFlags  out  3  {ADC select, shift, switcher} of the word currently emitting.
- LastFrameLength  out  13  final sextet count of the last completed frame.
- FrameCount  out  24  completed frames, wraps.
- SeqError  out  1  one-cycle pulse on a continuity violation.
- ErrorCount  out  ERR_W  saturating violation count.
- ClearStats  in  1  zeroes FrameCount, ErrorCount, LastFrameLength.

Behaviour:
- Reset (ResetN=0 at an edge):
  - All outputs 0; state HUNT; shift register, skid register and outstanding-read flag cleared.
  - Data from a read in flight at reset is discarded.
- States: HUNT, LOAD, EMIT.
- HUNT:
  - Issues FifoRead when FifoEmpty=0 and no read is outstanding.
  - Discards each returned word whose count is not 0.
  - On a word with count 0, loads it into the shift register and goes to EMIT.
- EMIT:
  - Bytes go out in order [7:0], [15:8], …, [47:40].
  - A byte advances only when SampleValid and SampleReady are both high.
  - SampleData, SampleIndex, FrameStart and HeaderFlags are stable while SampleValid=1 and SampleReady=0.
- Prefetch:
  - While in EMIT, issue FifoRead when the skid register is empty, no read is outstanding, and FifoEmpty=0.
  - The returned word is captured into the skid register.
  - After byte 5 is accepted:
    - skid full: move skid to the shift register in the same cycle and continue with no bubble (sustained 1 byte/cycle);
    - skid empty: go to LOAD, SampleValid=0, and wait for the next word.
  - At most one read is outstanding and at most one skid word is held; FifoRead is never asserted while the skid is full.
- Continuity check, applied when a word enters the shift register (prev = count of the previous word):
  - count == prev+1: normal continuation.
  - count == 0: frame boundary. LastFrameLength <= prev and FrameCount++, except for the first word after HUNT.
  - Any other value: SeqError pulses for one cycle and ErrorCount increments, saturating at all-ones. The word is dropped and the block returns to HUNT.
  - count == prev: the sextet is a duplicate. It is treated as a violation.
- SampleIndex = count*6 + byte position. Arithmetic is IDX_W wide with no overflow for counts ≤ 8191.
- ClearStats:
  - Takes priority over a same-cycle increment; the counters read 0 on the next cycle.
  - Does not affect the data path.
- Latency: the first byte is valid 2 cycles after the FifoRead that returns a count-0 word, i.e. capture plus load.

Optional Feature:
- SEQ_CHECK_EN.
- Defined:
  - HUNT synchronisation, the continuity check, SeqError and ErrorCount exist as above.
- Undefined:
  - The block leaves reset in LOAD and accepts any count; there is no hunting and no drop.
  - count==0 still drives FrameStart, FrameCount and LastFrameLength.
  - SeqError is tied to 0 and ErrorCount to 0.

Decomposition:
- Shared package holds:
  - field positions of the packed word (ADC_BIT=63, SHIFT_BIT=62, SW_BIT=61, CNT_MSB=60, CNT_LSB=48);
  - BYTES_PER_WORD=6 and CNT_W=13;
  - the state encoding.
- The packer uses the same constants.
- One sub-module, sextet_skid_reg: the one-entry prefetch buffer plus outstanding-read tracking with its FifoRead logic. The top level holds the FSM, the shifter and the statistics.

Test Plan:
- Reset then words with counts 5, 6, 0, 1 -> counts 5 and 6 dropped; 12 bytes out, FrameStart on the first byte of count 0, SampleIndex 0..11; SeqError never pulses.
- FIFO never empty, SampleReady=1 constantly, counts 0..99 -> 600 consecutive SampleValid cycles with no bubble after the first byte.
- Counts 0..7 then 0 -> LastFrameLength=7, FrameCount=1.
- Counts 0, 1, 3 -> one SeqError pulse, ErrorCount=1, no bytes from count 3, block hunts to the next 0.
- SampleReady toggled 1/0 during a word -> outputs held while stalled; byte order intact.
- ResetN low for one cycle while a FifoRead is outstanding -> all outputs 0, the in-flight word is ignored, and emission resumes only at the next count-0 word.
